// File: rtl/pipe_data_select_pkg.sv
// Shared defaults for the pipelined data-select block.
package pipe_data_select_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_NUM_IN = 3;
  localparam int DEF_SEL_W  = 2;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/pipe_sel_mux.sv
// Combinational NUM_IN:1 channel selector; out-of-range selects yield zero and flag an error.
module pipe_sel_mux #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_err
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_err = (32'(i_sel) >= NUM_IN);

endmodule

// File: rtl/pipe_data_select.sv
// Pipelined channel select with an output register plus one skid entry (2-beat FIFO).
// Handshakes: a beat moves on a rising edge where valid && ready; in_ready is registered.
module pipe_data_select
  import pipe_data_select_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        beat_cnt
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [WIDTH-1:0] w_mux_data;
  logic             w_mux_err;
  logic             w_accept;
  logic             w_deliver;
  logic             w_out_free;

  pipe_sel_mux #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_sel_mux (
    .i_sel (sel),
    .i_data(data),
    .o_data(w_mux_data),
    .o_err (w_mux_err)
  );

  assign w_accept   = in_valid && !r_skid_valid;
  assign w_deliver  = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || w_deliver;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      if (w_deliver) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
        // Skid has priority when OUT frees up; in_ready was low so nothing new arrives.
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_err    <= r_skid_err;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_mux_data;
          r_out_err   <= w_mux_err;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_mux_data;
        r_skid_err   <= w_mux_err;
      end
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;
  assign result    = r_out_data;
  assign sel_err   = r_out_err;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_pipe_data_select.sv
// Bench for pipe_data_select: a 2-deep FIFO reference model with per-feature test tasks.
module tb_pipe_data_select;

  localparam int WIDTH  = 5;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam int DW     = NUM_IN * WIDTH;

  logic              CLK;
  logic              Reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  sel;
  logic [DW-1:0]     data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              sel_err;
  logic [15:0]       beat_cnt;

  pipe_data_select #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .data     (data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .sel_err  (sel_err),
    .beat_cnt (beat_cnt)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Scoreboard: each entry is {sel_err, result} of a buffered beat, head first.
  logic [WIDTH:0] exp_q[$];
  logic [15:0]    m_cnt;
  int             n_vec;
  int             n_err;

  function automatic logic [WIDTH:0] model_select(input logic [SEL_W-1:0] s,
                                                  input logic [DW-1:0] d);
    int unsigned sv;
    int unsigned dv;
    sv = int'(s);
    dv = int'(d);
    if (sv >= NUM_IN) return {1'b1, {WIDTH{1'b0}}};
    return {1'b0, WIDTH'((dv >> (sv * WIDTH)) % (1 << WIDTH))};
  endfunction

  // Driver: called at a falling edge; applies inputs, updates the model at the
  // rising edge, and returns at the next falling edge ready for sampling.
  task automatic drive_cycle(input logic rst, input logic fl, input logic iv,
                             input logic [SEL_W-1:0] s, input logic [DW-1:0] d,
                             input logic ordy);
    bit deliver;
    bit accept;
    Reset     = rst;
    flush     = fl;
    in_valid  = iv;
    sel       = s;
    data      = d;
    out_ready = ordy;
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
      m_cnt = '0;
    end else begin
      deliver = (exp_q.size() > 0) && ordy;
      accept  = iv && (exp_q.size() < 2);
      if (deliver) begin
        m_cnt = m_cnt + 16'd1;
        void'(exp_q.pop_front());
      end
      if (fl) exp_q.delete();
      else if (accept) exp_q.push_back(model_select(s, d));
    end
    @(negedge CLK);
  endtask

  task automatic idle(input logic ordy);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 2'd1, 15'h7fff, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 2'd2, 15'h1234, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    n_vec++;
    if (result !== '0 || sel_err !== 1'b0 || beat_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_val: result=%0d sel_err=%b beat_cnt=%0d required 0/0/0",
               result, sel_err, beat_cnt);
    end
    idle(1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drop: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_basic();
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd1, {5'd3, 5'd17, 5'd9}, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || result !== 5'd17 || sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_select: out_valid=%b result=%0d sel_err=%b required 1/17/0",
               out_valid, result, sel_err);
    end
    idle(1'b1);
    n_vec++;
    if (beat_cnt !== 16'd1 || beat_cnt !== m_cnt || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count: beat_cnt=%0d out_valid=%b required 1/0", beat_cnt, out_valid);
    end
  endtask

  task automatic test_skid();
    logic [15:0] c0;
    c0 = m_cnt;
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, {5'd0, 5'd0, 5'd5}, 1'b0);
    n_vec++;
    if (in_ready !== 1'b1 || result !== 5'd5) begin
      n_err++;
      $display("FAIL skid_first: in_ready=%b result=%0d required 1/5", in_ready, result);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, {5'd0, 5'd0, 5'd6}, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 5'd5) begin
      n_err++;
      $display("FAIL skid_full: in_ready=%b out_valid=%b result=%0d required 0/1/5",
               in_ready, out_valid, result);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, {5'd0, 5'd0, 5'd7}, 1'b0);
    n_vec++;
    if (result !== 5'd5 || in_ready !== 1'b0 || exp_q.size() != 2) begin
      n_err++;
      $display("FAIL skid_stall: result=%0d in_ready=%b required 5/0", result, in_ready);
    end
    idle(1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || result !== 5'd6 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL skid_drain1: out_valid=%b result=%0d in_ready=%b required 1/6/1",
               out_valid, result, in_ready);
    end
    idle(1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || beat_cnt !== c0 + 16'd2) begin
      n_err++;
      $display("FAIL skid_drain2: out_valid=%b beat_cnt=%0d required 0/%0d",
               out_valid, beat_cnt, c0 + 16'd2);
    end
  endtask

  task automatic test_sel_err();
    logic [15:0] c0;
    c0 = m_cnt;
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd3, 15'h7fff, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || result !== 5'd0 || sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL sel_err_flag: out_valid=%b result=%0d sel_err=%b required 1/0/1",
               out_valid, result, sel_err);
    end
    idle(1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || beat_cnt !== c0 + 16'd1) begin
      n_err++;
      $display("FAIL sel_err_count: out_valid=%b beat_cnt=%0d required 0/%0d",
               out_valid, beat_cnt, c0 + 16'd1);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd2, {5'd11, 5'd0, 5'd0}, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, 2'd2, {5'd12, 5'd0, 5'd0}, 1'b0);
    c0 = m_cnt;
    n_vec++;
    if (in_ready !== 1'b0 || result !== 5'd11) begin
      n_err++;
      $display("FAIL flush_fill: in_ready=%b result=%0d required 0/11", in_ready, result);
    end
    // Delivery in the flush cycle still counts.
    drive_cycle(1'b0, 1'b1, 1'b1, 2'd2, {5'd13, 5'd0, 5'd0}, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || beat_cnt !== c0 + 16'd1) begin
      n_err++;
      $display("FAIL flush_clear: out_valid=%b in_ready=%b beat_cnt=%0d required 0/1/%0d",
               out_valid, in_ready, beat_cnt, c0 + 16'd1);
    end
    idle(1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || beat_cnt !== m_cnt) begin
      n_err++;
      $display("FAIL flush_gone: out_valid=%b beat_cnt=%0d required 0/%0d",
               out_valid, beat_cnt, m_cnt);
    end
  endtask

  task automatic test_random();
    logic           iv;
    logic           ordy;
    logic           fl;
    logic           stall;
    logic [WIDTH:0] held;
    for (int i = 0; i < 10000; i++) begin
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      fl    = ($urandom_range(0, 63) == 0);
      stall = (exp_q.size() > 0) && !ordy && !fl;
      held  = (exp_q.size() > 0) ? exp_q[0] : '0;
      drive_cycle(1'b0, fl, iv, SEL_W'($urandom_range(0, 3)), DW'($urandom()), ordy);
      n_vec++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
        n_err++;
        $display("FAIL rand_hs[%0d]: out_valid=%b in_ready=%b required %b/%b", i,
                 out_valid, in_ready, exp_q.size() > 0, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        if ({sel_err, result} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rand_data[%0d]: err/result=%b/%0d required %b/%0d", i,
                   sel_err, result, exp_q[0][WIDTH], exp_q[0][WIDTH-1:0]);
        end
      end
      if (stall) begin
        n_vec++;
        if ({sel_err, result} !== held) begin
          n_err++;
          $display("FAIL rand_stable[%0d]: err/result=%b/%0d required %b/%0d", i,
                   sel_err, result, held[WIDTH], held[WIDTH-1:0]);
        end
      end
      n_vec++;
      if (beat_cnt !== m_cnt) begin
        n_err++;
        $display("FAIL rand_cnt[%0d]: beat_cnt=%0d required %0d", i, beat_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (m_cnt != 16'hffff && guard < 70000) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 2'd0, DW'(guard), 1'b1);
      guard++;
    end
    n_vec++;
    if (beat_cnt !== 16'hffff || m_cnt != 16'hffff) begin
      n_err++;
      $display("FAIL wrap_pre: beat_cnt=%h required ffff (guard=%0d)", beat_cnt, guard);
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_ready: out_valid=%b required 1", out_valid);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
    n_vec++;
    if (beat_cnt !== 16'h0000 || beat_cnt !== m_cnt) begin
      n_err++;
      $display("FAIL wrap_post: beat_cnt=%h required 0000", beat_cnt);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    m_cnt     = '0;
    Reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    sel       = '0;
    data      = '0;
    out_ready = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_skid();
    test_sel_err();
    test_flush();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
